// File: rtl/table_nmu_pkg.sv
// ----------------------------------------------------------------------------
// table_nmu_pkg
//   Shared definitions for the table-driven NMU: MAC width, the broadcast
//   address and the ingress FSM state encoding.
//   No ports (package).
// ----------------------------------------------------------------------------
package table_nmu_pkg;
   localparam int               MAC_W     = 48;
   localparam logic [MAC_W-1:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

   // FIRST: classifying the head beat, FWD/DROP: body beats of a packet
   typedef enum logic [1:0] {
      ST_FIRST = 2'd0,
      ST_FWD   = 2'd1,
      ST_DROP  = 2'd2
   } state_e;
endpackage

// File: rtl/nmu_mac_table.sv
// ----------------------------------------------------------------------------
// nmu_mac_table
//   Programmable MAC -> tdest table with a single write port and a fully
//   parallel lookup. Among several valid matches the lowest index wins.
// Ports
//   clk_i, rst_ni     clock, async active-low reset (clears valid bits)
//   wr_en_i           write strobe, one entry per cycle
//   wr_idx_i          entry index; indices with no entry never match
//   wr_valid_i        valid bit to store
//   wr_mac_i          MAC to store (byte0 in [7:0])
//   wr_dest_i         tdest to store
//   lkp_mac_i         MAC to look up (combinational, sees pre-write contents)
//   hit_o, dest_o     lookup result
// ----------------------------------------------------------------------------
module nmu_mac_table
   import table_nmu_pkg::*;
#(
   parameter  int NUM_ENTRIES = 8,
   parameter  int ID_W        = 4,
   localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_valid_i,
   input  logic [MAC_W-1:0] wr_mac_i,
   input  logic [ID_W-1:0]  wr_dest_i,
   input  logic [MAC_W-1:0] lkp_mac_i,
   output logic             hit_o,
   output logic [ID_W-1:0]  dest_o
);

   logic [NUM_ENTRIES-1:0]            vld_q;
   logic [NUM_ENTRIES-1:0][MAC_W-1:0] mac_q;
   logic [NUM_ENTRIES-1:0][ID_W-1:0]  dest_q;
   logic [NUM_ENTRIES-1:0]            match;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q  <= '0;
         mac_q  <= '0;
         dest_q <= '0;
      end else begin
         for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (wr_en_i && (wr_idx_i == IDX_W'(e))) begin
               vld_q[e]  <= wr_valid_i;
               mac_q[e]  <= wr_mac_i;
               dest_q[e] <= wr_dest_i;
            end
         end
      end
   end

   for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_cmp
      assign match[e] = vld_q[e] && (mac_q[e] == lkp_mac_i);
   end

   // Walk from the top down so the lowest matching index is assigned last.
   always_comb begin
      hit_o  = 1'b0;
      dest_o = '0;
      for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
         if (match[e]) begin
            hit_o  = 1'b1;
            dest_o = dest_q[e];
         end
      end
   end

endmodule

// File: rtl/table_nmu.sv
// ----------------------------------------------------------------------------
// table_nmu
//   Network management unit between the shared network port and the
//   per-tenant AXI-Stream switch. Egress is a combinational passthrough.
//   Ingress is zero-latency: the head beat's destination MAC is looked up in
//   a programmable table, the resulting tdest is held for the whole packet,
//   and broadcast/miss packets are steered or sunk as parameterised.
// Ports
//   aclk, aresetn            clock, async active-low reset
//   axis_egr_in_* / _out_*   egress stream, straight copy (tready flows back)
//   axis_ingr_in_*           ingress from the network port
//   axis_ingr_out_*          ingress to the switch, plus tdest
//   cfg_wr_*                 table write port
//   stat_clr                 synchronous clear of both counters
//   stat_fwd_pkts/drop_pkts  saturating packet counters
// ----------------------------------------------------------------------------
module table_nmu
   import table_nmu_pkg::*;
#(
   parameter  int AXIS_BUS_WIDTH = 64,
   parameter  int AXIS_ID_WIDTH  = 4,
   parameter  int NUM_ENTRIES    = 8,
   parameter  int MISS_DROP      = 1,
   parameter  int DEFAULT_DEST   = 0,
   parameter  int BCAST_DEST     = 0,
   parameter  int CNT_WIDTH      = 32,
   localparam int KEEP_W         = AXIS_BUS_WIDTH / 8,
   localparam int IDX_W          = $clog2(NUM_ENTRIES)
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [AXIS_BUS_WIDTH-1:0] axis_egr_in_tdata,
   input  logic [KEEP_W-1:0]         axis_egr_in_tkeep,
   input  logic                      axis_egr_in_tlast,
   input  logic                      axis_egr_in_tvalid,
   output logic                      axis_egr_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0] axis_egr_out_tdata,
   output logic [KEEP_W-1:0]         axis_egr_out_tkeep,
   output logic                      axis_egr_out_tlast,
   output logic                      axis_egr_out_tvalid,
   input  logic                      axis_egr_out_tready,
   input  logic [AXIS_BUS_WIDTH-1:0] axis_ingr_in_tdata,
   input  logic [KEEP_W-1:0]         axis_ingr_in_tkeep,
   input  logic                      axis_ingr_in_tlast,
   input  logic                      axis_ingr_in_tvalid,
   output logic                      axis_ingr_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0] axis_ingr_out_tdata,
   output logic [KEEP_W-1:0]         axis_ingr_out_tkeep,
   output logic                      axis_ingr_out_tlast,
   output logic                      axis_ingr_out_tvalid,
   output logic [AXIS_ID_WIDTH-1:0]  axis_ingr_out_tdest,
   input  logic                      axis_ingr_out_tready,
   input  logic                      cfg_wr_en,
   input  logic [IDX_W-1:0]          cfg_wr_idx,
   input  logic                      cfg_wr_valid,
   input  logic [MAC_W-1:0]          cfg_wr_mac,
   input  logic [AXIS_ID_WIDTH-1:0]  cfg_wr_dest,
   input  logic                      stat_clr,
   output logic [CNT_WIDTH-1:0]      stat_fwd_pkts,
   output logic [CNT_WIDTH-1:0]      stat_drop_pkts
);

   localparam logic [AXIS_ID_WIDTH-1:0] DEF_D   = AXIS_ID_WIDTH'(DEFAULT_DEST);
   localparam logic [AXIS_ID_WIDTH-1:0] BCAST_D = AXIS_ID_WIDTH'(BCAST_DEST);

   state_e                     state_q;
   logic [AXIS_ID_WIDTH-1:0]   dest_q;
   logic [CNT_WIDTH-1:0]       fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;

   logic                       tbl_hit;
   logic [AXIS_ID_WIDTH-1:0]   tbl_dest;
   logic                       cls_fwd, cur_fwd, beat, last_beat;
   logic [AXIS_ID_WIDTH-1:0]   cls_dest, cur_dest;
   logic [MAC_W-1:0]           dmac;

   // ---------------- egress ----------------
   assign axis_egr_out_tdata  = axis_egr_in_tdata;
   assign axis_egr_out_tkeep  = axis_egr_in_tkeep;
   assign axis_egr_out_tlast  = axis_egr_in_tlast;
   assign axis_egr_out_tvalid = axis_egr_in_tvalid;
   assign axis_egr_in_tready  = axis_egr_out_tready;

   // ---------------- lookup ----------------
   assign dmac = axis_ingr_in_tdata[MAC_W-1:0];

   nmu_mac_table #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .ID_W        (AXIS_ID_WIDTH)
   ) u_tbl (
      .clk_i      (aclk),
      .rst_ni     (aresetn),
      .wr_en_i    (cfg_wr_en),
      .wr_idx_i   (cfg_wr_idx),
      .wr_valid_i (cfg_wr_valid),
      .wr_mac_i   (cfg_wr_mac),
      .wr_dest_i  (cfg_wr_dest),
      .lkp_mac_i  (dmac),
      .hit_o      (tbl_hit),
      .dest_o     (tbl_dest)
   );

   // Head-beat classification. A head beat that does not carry all six MAC
   // bytes cannot be trusted and is treated as a miss, even for broadcast.
   always_comb begin
      cls_fwd  = (MISS_DROP == 0);
      cls_dest = DEF_D;
      if (axis_ingr_in_tkeep[5:0] == 6'h3F) begin
         if (dmac == MAC_BCAST) begin
            cls_fwd  = 1'b1;
            cls_dest = BCAST_D;
         end else if (tbl_hit) begin
            cls_fwd  = 1'b1;
            cls_dest = tbl_dest;
         end
      end
   end

   always_comb begin
      cur_fwd  = cls_fwd;
      cur_dest = cls_dest;
      if (state_q == ST_FWD) begin
         cur_fwd  = 1'b1;
         cur_dest = dest_q;
      end else if (state_q == ST_DROP) begin
         cur_fwd  = 1'b0;
         cur_dest = dest_q;
      end
   end

   // ---------------- ingress datapath ----------------
   assign axis_ingr_out_tdata  = axis_ingr_in_tdata;
   assign axis_ingr_out_tkeep  = axis_ingr_in_tkeep;
   assign axis_ingr_out_tlast  = axis_ingr_in_tlast;
   assign axis_ingr_out_tdest  = cur_dest;
   assign axis_ingr_out_tvalid = aresetn && cur_fwd && axis_ingr_in_tvalid;
   // Dropped packets are sunk at line rate regardless of downstream backpressure.
   assign axis_ingr_in_tready  = aresetn && (cur_fwd ? axis_ingr_out_tready : 1'b1);

   assign beat      = axis_ingr_in_tvalid && axis_ingr_in_tready;
   assign last_beat = beat && axis_ingr_in_tlast;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_FIRST;
         dest_q  <= '0;
      end else begin
         case (state_q)
            ST_FIRST: if (beat && !axis_ingr_in_tlast) begin
               dest_q  <= cls_dest;
               state_q <= cls_fwd ? ST_FWD : ST_DROP;
            end
            ST_FWD, ST_DROP: if (last_beat) state_q <= ST_FIRST;
            default: state_q <= ST_FIRST;
         endcase
      end
   end

   // ---------------- statistics ----------------
   always_comb begin
      fwd_cnt_d  = fwd_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (stat_clr) begin
         fwd_cnt_d  = '0;
         drop_cnt_d = '0;
      end else if (last_beat) begin
         if (cur_fwd && !(&fwd_cnt_q))
            fwd_cnt_d = fwd_cnt_q + CNT_WIDTH'(1);
         if (!cur_fwd && !(&drop_cnt_q))
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         fwd_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         fwd_cnt_q  <= fwd_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign stat_fwd_pkts  = fwd_cnt_q;
   assign stat_drop_pkts = drop_cnt_q;

endmodule

// File: tb/tb_table_nmu.sv
// ----------------------------------------------------------------------------
// tb_table_nmu
//   Two NMU instances share one clock/reset: instance 0 drops on a miss,
//   instance 1 forwards misses to tdest 7. Both use BCAST_DEST=3 and 4-bit
//   counters. A behavioural model (table array, per-packet decision,
//   integer counters) predicts every ingress cycle.
// ----------------------------------------------------------------------------
module tb_table_nmu;
   localparam int W = 64, KW = 8, IDW = 4, CW = 4;
   localparam logic [47:0] MAC_A = 48'h05_00_00_00_00_02; // 02:00:00:00:00:05
   localparam logic [47:0] MAC_B = 48'h66_55_44_33_22_11;
   localparam logic [47:0] MAC_C = 48'hAA_00_00_00_00_0C;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   logic aclk = 1'b0, aresetn;
   always #5 aclk = ~aclk;

   logic [W-1:0]           eg_data;
   logic [KW-1:0]          eg_keep;
   logic                   eg_last, eg_valid;
   logic [1:0]             eo_ready, ei_ready, eo_valid, eo_last;
   logic [1:0][W-1:0]      eo_data, i_data, o_data;
   logic [1:0][KW-1:0]     eo_keep, i_keep, o_keep;
   logic [1:0]             i_last, i_valid, i_ready, o_last, o_valid, o_ready;
   logic [1:0][IDW-1:0]    o_dest, wr_dest;
   logic [1:0]             wr_en, wr_valid, stat_clr;
   logic [1:0][2:0]        wr_idx;
   logic [1:0][47:0]       wr_mac;
   logic [1:0][CW-1:0]     s_fwd, s_drop;

   for (genvar u = 0; u < 2; u++) begin : g_dut
      table_nmu #(
         .AXIS_BUS_WIDTH (W),
         .AXIS_ID_WIDTH  (IDW),
         .NUM_ENTRIES    (8),
         .MISS_DROP      ((u == 0) ? 1 : 0),
         .DEFAULT_DEST   (7),
         .BCAST_DEST     (3),
         .CNT_WIDTH      (CW)
      ) dut (
         .aclk                 (aclk),
         .aresetn              (aresetn),
         .axis_egr_in_tdata    (eg_data),
         .axis_egr_in_tkeep    (eg_keep),
         .axis_egr_in_tlast    (eg_last),
         .axis_egr_in_tvalid   (eg_valid),
         .axis_egr_in_tready   (ei_ready[u]),
         .axis_egr_out_tdata   (eo_data[u]),
         .axis_egr_out_tkeep   (eo_keep[u]),
         .axis_egr_out_tlast   (eo_last[u]),
         .axis_egr_out_tvalid  (eo_valid[u]),
         .axis_egr_out_tready  (eo_ready[u]),
         .axis_ingr_in_tdata   (i_data[u]),
         .axis_ingr_in_tkeep   (i_keep[u]),
         .axis_ingr_in_tlast   (i_last[u]),
         .axis_ingr_in_tvalid  (i_valid[u]),
         .axis_ingr_in_tready  (i_ready[u]),
         .axis_ingr_out_tdata  (o_data[u]),
         .axis_ingr_out_tkeep  (o_keep[u]),
         .axis_ingr_out_tlast  (o_last[u]),
         .axis_ingr_out_tvalid (o_valid[u]),
         .axis_ingr_out_tdest  (o_dest[u]),
         .axis_ingr_out_tready (o_ready[u]),
         .cfg_wr_en            (wr_en[u]),
         .cfg_wr_idx           (wr_idx[u]),
         .cfg_wr_valid         (wr_valid[u]),
         .cfg_wr_mac           (wr_mac[u]),
         .cfg_wr_dest          (wr_dest[u]),
         .stat_clr             (stat_clr[u]),
         .stat_fwd_pkts        (s_fwd[u]),
         .stat_drop_pkts       (s_drop[u])
      );
   end

   // ---------------- reference model ----------------
   logic [1:0][7:0] m_vld;
   logic [47:0]     m_mac [2][8];
   logic [3:0]      m_dst [2][8];
   int              m_fwd [2];
   int              m_drop[2];

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   // Destination decision straight from the routing rules.
   function automatic void classify(input int u, input logic [63:0] d, input logic [7:0] k,
                                    output bit fwd, output logic [3:0] dst);
      fwd = (u != 0);
      dst = 4'd7;
      if (k[5:0] != 6'h3F) return;
      if (d[47:0] == BCAST) begin
         fwd = 1'b1; dst = 4'd3; return;
      end
      for (int e = 0; e < 8; e++)
         if (m_vld[u][e] && m_mac[u][e] == d[47:0]) begin
            fwd = 1'b1; dst = m_dst[u][e]; return;
         end
   endfunction

   task automatic drive_egress();
      eg_data  = {$urandom(), $urandom()};
      eg_keep  = 8'($urandom());
      eg_last  = 1'($urandom());
      eg_valid = 1'($urandom());
      eo_ready = 2'($urandom());
   endtask

   task automatic chk_egress();
      for (int u = 0; u < 2; u++) begin
         chk("egr_data", eo_data[u], eg_data);
         chk("egr_ctl", {eo_keep[u], eo_last[u], eo_valid[u], ei_ready[u]},
                        {eg_keep, eg_last, eg_valid, eo_ready[u]});
      end
   endtask

   task automatic chk_cnt(input int u);
      chk("stat_fwd", s_fwd[u], m_fwd[u]);
      chk("stat_drop", s_drop[u], m_drop[u]);
   endtask

   task automatic cfg_write(input int u, input logic [2:0] wi, input logic wv,
                            input logic [47:0] wm, input logic [3:0] wd);
      wr_en[u] = 1'b1; wr_idx[u] = wi; wr_valid[u] = wv; wr_mac[u] = wm; wr_dest[u] = wd;
      @(posedge aclk);
      m_vld[u][wi] = wv; m_mac[u][wi] = wm; m_dst[u][wi] = wd;
      #1 wr_en[u] = 1'b0;
   endtask

   task automatic do_clr(input int u);
      stat_clr[u] = 1'b1;
      @(posedge aclk);
      m_fwd[u] = 0; m_drop[u] = 0;
      #1 stat_clr[u] = 1'b0;
   endtask

   // Sends one packet with random valid/ready gaps; optionally issues a table
   // write during beat wb. Called and returns at posedge+1.
   task automatic send_pkt(input int u, input logic [47:0] mac, input int nb, input logic [7:0] k0,
                           input int wb, input logic wv, input logic [2:0] wi,
                           input logic [47:0] wm, input logic [3:0] wd);
      int b = 0, cyc = 0;
      bit pf = 1'b0, beat, ev, er;
      logic [3:0] pd = '0;
      logic [63:0] cur;
      cur = {16'($urandom()), mac};
      while (b < nb) begin
         i_valid[u] = ($urandom_range(0, 3) != 0);
         o_ready[u] = ($urandom_range(0, 3) != 0);
         i_data[u]  = cur;
         i_keep[u]  = (b == 0) ? k0 : 8'hFF;
         i_last[u]  = (b == nb - 1);
         wr_en[u] = (b == wb); wr_valid[u] = wv; wr_idx[u] = wi; wr_mac[u] = wm; wr_dest[u] = wd;
         drive_egress();
         @(negedge aclk);
         if (b == 0) classify(u, cur, k0, pf, pd);
         ev = pf && i_valid[u];
         er = pf ? o_ready[u] : 1'b1;
         chk("ingr_tvalid", o_valid[u], ev);
         chk("ingr_tready", i_ready[u], er);
         if (ev) begin
            chk("ingr_tdest", o_dest[u], pd);
            chk("ingr_tdata", o_data[u], cur);
            chk("ingr_keep_last", {o_keep[u], o_last[u]}, {i_keep[u], b == nb - 1});
         end
         chk_cnt(u);
         chk_egress();
         beat = i_valid[u] && er;
         @(posedge aclk);
         if (wr_en[u]) begin
            m_vld[u][wi] = wv; m_mac[u][wi] = wm; m_dst[u][wi] = wd;
         end
         if (stat_clr[u]) begin
            m_fwd[u] = 0; m_drop[u] = 0;
         end else if (beat && b == nb - 1) begin
            if (pf) m_fwd[u] = sat(m_fwd[u] + 1);
            else    m_drop[u] = sat(m_drop[u] + 1);
         end
         if (beat) begin
            b++;
            cur = {$urandom(), $urandom()};
         end
         #1;
         cyc++;
         if (cyc > 500) begin
            chk("pkt_timeout", 64'(b), 64'(nb));
            break;
         end
      end
      i_valid[u] = 1'b0;
      wr_en[u]   = 1'b0;
   endtask

   task automatic pkt(input int u, input logic [47:0] mac, input int nb);
      send_pkt(u, mac, nb, 8'hFF, -1, 1'b0, 3'd0, 48'h0, 4'd0);
   endtask

   logic [47:0] pool[5];

   initial begin
      aresetn = 1'b0;
      i_valid = '0; o_ready = '0; i_data = '0; i_keep = '0; i_last = '0;
      wr_en = '0; wr_valid = '0; wr_idx = '0; wr_mac = '0; wr_dest = '0; stat_clr = '0;
      m_vld = '0; m_fwd = '{0, 0}; m_drop = '{0, 0};
      pool = '{MAC_A, MAC_B, MAC_C, BCAST, 48'h0};

      // reset: ingress closed even with traffic offered, egress still flows
      drive_egress();
      i_valid = 2'b11; o_ready = 2'b11;
      i_data  = {2{16'h0, BCAST}}; i_keep = {2{8'hFF}};
      @(negedge aclk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_tready", i_ready[u], 1'b0);
         chk("rst_tvalid", o_valid[u], 1'b0);
         chk_cnt(u);
      end
      chk_egress();
      @(posedge aclk); #1;
      i_valid = '0;
      aresetn = 1'b1;

      // basic hit, miss drop / miss default, broadcast priority, lowest index
      for (int u = 0; u < 2; u++) begin
         cfg_write(u, 3'd2, 1'b1, MAC_A, 4'd5);
         pkt(u, MAC_A, 4);
         pkt(u, MAC_C, 3);
         cfg_write(u, 3'd0, 1'b1, BCAST, 4'd1);
         pkt(u, BCAST, 2);
         cfg_write(u, 3'd1, 1'b1, MAC_B, 4'd4);
         cfg_write(u, 3'd6, 1'b1, MAC_B, 4'd9);
         pkt(u, MAC_B, 3);
         // back-to-back: single-beat then 5-beat to a different MAC
         pkt(u, MAC_A, 1);
         pkt(u, MAC_B, 5);
         // rewrite mid-packet, then at the head beat (lookup sees old contents)
         send_pkt(u, MAC_A, 4, 8'hFF, 2, 1'b1, 3'd2, MAC_A, 4'd6);
         pkt(u, MAC_A, 2);
         send_pkt(u, MAC_A, 3, 8'hFF, 0, 1'b1, 3'd2, MAC_A, 4'd5);
         pkt(u, MAC_A, 2);
         // short head beat always misses
         send_pkt(u, MAC_A, 2, 8'h0F, -1, 1'b0, 3'd0, 48'h0, 4'd0);
      end

      // randomized traffic and table churn
      for (int n = 0; n < 40; n++) begin
         int u, nb, wb;
         u  = $urandom_range(0, 1);
         nb = $urandom_range(1, 5);
         wb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
         pool[4] = {$urandom(), 16'($urandom())};
         send_pkt(u, pool[$urandom_range(0, 4)], nb,
                  ($urandom_range(0, 7) == 0) ? 8'h1F : 8'hFF,
                  wb, 1'($urandom()), 3'($urandom()), pool[$urandom_range(0, 3)], 4'($urandom()));
      end

      // saturation and clear priority
      cfg_write(0, 3'd2, 1'b1, MAC_A, 4'd5);
      do_clr(0);
      for (int n = 0; n < 16; n++) pkt(0, MAC_A, 1);
      @(negedge aclk);
      chk("fwd_saturated", s_fwd[0], 4'hF);
      @(posedge aclk); #1;
      stat_clr[0] = 1'b1;
      pkt(0, MAC_A, 1);
      stat_clr[0] = 1'b0;
      @(negedge aclk);
      chk("clr_beats_inc", s_fwd[0], 4'h0);
      @(posedge aclk); #1;

      // reset in the middle of a forwarded packet
      cfg_write(0, 3'd2, 1'b1, MAC_A, 4'd5);
      i_valid[0] = 1'b1; o_ready[0] = 1'b1;
      i_data[0] = {16'h0, MAC_A}; i_keep[0] = 8'hFF; i_last[0] = 1'b0;
      @(negedge aclk);
      chk("pre_rst_tvalid", o_valid[0], 1'b1);
      chk("pre_rst_tdest", o_dest[0], 4'd5);
      @(posedge aclk); #1;
      i_data[0] = {$urandom(), $urandom()};
      drive_egress();
      aresetn = 1'b0;
      #1;
      chk("midrst_tready", i_ready[0], 1'b0);
      chk("midrst_tvalid", o_valid[0], 1'b0);
      chk_egress();
      @(posedge aclk); #1;
      aresetn = 1'b1;
      i_valid[0] = 1'b0;
      m_vld = '0; m_fwd = '{0, 0}; m_drop = '{0, 0};
      pkt(0, MAC_A, 2);
      pkt(1, MAC_A, 2);
      @(negedge aclk);
      chk("post_rst_drop", s_drop[0], 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
